imm_extend_pipe: RTL and testbench

Parametrised, pipelined RISC-V immediate generator for the processor datapath. It accepts a 32-bit instruction word through a valid/ready handshake, classifies the encoding format and produces the sign- or zero-extended XLEN-bit immediate two cycles later. It supports all base formats (I, S, B, U, J) plus shift-amount immediates. It also supports backpressure, pipeline flush and illegal-opcode tracking, and sits between instruction fetch/decode and the ALU/branch operand muxes.

---
 rtl/imm_extend_pipe.sv | 169 ++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage RISC-V immediate generator: stage 1 captures the instruction and its
// decoded format, stage 2 builds the XLEN-bit immediate and drives the outputs.
module imm_extend_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [7:0]      err_count
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  // funct3 of 001 or 101 selects the shift-amount form of the OP-IMM opcodes.
  function automatic logic [2:0] decode_fmt(input logic [31:0] w);
    logic [2:0] f;
    logic       is_shift;
    is_shift = (w[13:12] == 2'b01);
    case (w[6:0])
      7'b0010011: f = is_shift ? FMT_SHAMT : FMT_I;
      7'b0011011: begin
        if (XLEN == 64) f = is_shift ? FMT_SHAMT : FMT_I;
        else            f = FMT_NONE;
      end
      7'b0000011: f = FMT_I;
      7'b1100111: f = FMT_I;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111: f = FMT_U;
      7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      default:    f = FMT_NONE;
    endcase
    return f;
  endfunction

  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] w, input logic [2:0] f);
    logic [31:0]     v;
    logic [XLEN-1:0] r;
    case (f)
      FMT_I:   v = {{20{w[31]}}, w[31:20]};
      FMT_S:   v = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   v = {w[31:12], 12'd0};
      FMT_J:   v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: v = 32'd0;
    endcase
    // Only the RV64 OP-IMM shifts carry a 6-bit shamt; word shifts and RV32 use 5 bits.
    if (f == FMT_SHAMT) begin
      if ((XLEN == 64) && (w[6:0] == 7'b0010011)) r = XLEN'(w[25:20]);
      else                                         r = XLEN'(w[24:20]);
    end else begin
      r = XLEN'($signed(v));
    end
    return r;
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_inst_q,  s1_inst_d;
  logic [2:0]      s1_fmt_q,   s1_fmt_d;
  logic            s1_ill_q,   s1_ill_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [2:0]      fmt_q,      fmt_d;
  logic            ill_q,      ill_d;
  logic [7:0]      err_q,      err_d;

  logic            s2_load_s;
  logic            s1_adv_s;
  logic            in_fire_s;
  logic            out_fire_s;
  logic [2:0]      in_fmt_s;

  assign s2_load_s  = !s2_valid_q || out_ready;
  assign s1_adv_s   = s1_valid_q && s2_load_s;
  assign in_ready   = !flush && (!s1_valid_q || s2_load_s);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = s2_valid_q && out_ready;
  assign in_fmt_s   = decode_fmt(inst);

  // Next-state for both stages and the error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_inst_d  = s1_inst_q;
    s1_fmt_d   = s1_fmt_q;
    s1_ill_d   = s1_ill_q;
    s2_valid_d = s2_valid_q;
    imm_d      = imm_q;
    fmt_d      = fmt_q;
    ill_d      = ill_q;
    err_d      = err_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (!s1_valid_q || s2_load_s) s1_valid_d = in_fire_s;
      else                          s1_valid_d = s1_valid_q;
      if (s2_load_s) s2_valid_d = s1_valid_q;
      else           s2_valid_d = s2_valid_q;
    end

    if (in_fire_s) begin
      s1_inst_d = inst;
      s1_fmt_d  = in_fmt_s;
      s1_ill_d  = (in_fmt_s == FMT_NONE);
    end else begin
      s1_inst_d = s1_inst_q;
    end

    if (!flush && s1_adv_s) begin
      imm_d = build_imm(s1_inst_q, s1_fmt_q);
      fmt_d = s1_fmt_q;
      ill_d = s1_ill_q;
    end else begin
      imm_d = imm_q;
    end

    // A flush does not cancel the delivery happening in the same cycle.
    if (out_fire_s && ill_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    else                                         err_d = err_q;
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= 32'd0;
      s1_fmt_q   <= FMT_NONE;
      s1_ill_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      imm_q      <= {XLEN{1'b0}};
      fmt_q      <= FMT_NONE;
      ill_q      <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_inst_q  <= s1_inst_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_ill_q   <= s1_ill_d;
      s2_valid_q <= s2_valid_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      ill_q      <= ill_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = ill_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: an RV64 and an RV32 instance share one stimulus stream and are
// each checked against an arithmetic reference model of the immediate rules.
`timescale 1ns/1ps
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] inst;
  logic        flush;
  logic        out_ready;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  err64;
  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  err32;

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64), .inst(inst),
    .flush(flush), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(illegal64), .err_count(err64));

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32), .inst(inst),
    .flush(flush), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .fmt(fmt32), .illegal(illegal32), .err_count(err32));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_err64  = 0;
  int   exp_err32  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] w, input int xl);
    exp_t       e;
    longint     v;
    logic [6:0] op;
    logic [2:0] f3;
    op    = w[6:0];
    f3    = w[14:12];
    v     = 0;
    e.fmt = 3'd0;
    if ((op == 7'h13 || (op == 7'h1B && xl == 64)) && (f3 == 3'd1 || f3 == 3'd5)) begin
      e.fmt = 3'd6;
      if (op == 7'h13 && xl == 64) v = longint'(w[25:20]);
      else                         v = longint'(w[24:20]);
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (op == 7'h1B && xl == 64)) begin
      e.fmt = 3'd1;
      v = longint'(w[31:20]);
      if (v >= 2048) v -= 4096;
    end else if (op == 7'h23) begin
      e.fmt = 3'd2;
      v = longint'({w[31:25], w[11:7]});
      if (v >= 2048) v -= 4096;
    end else if (op == 7'h63) begin
      e.fmt = 3'd3;
      v = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2;
      if (v >= 4096) v -= 8192;
    end else if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd4;
      v = longint'(w[31:12]) * 4096;
      if (w[31]) v -= 64'sd4294967296;
    end else if (op == 7'h6F) begin
      e.fmt = 3'd5;
      v = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2;
      if (v >= 1048576) v -= 2097152;
    end
    e.ill = (e.fmt == 3'd0);
    if (xl == 64) e.imm = 64'(v);
    else          e.imm = {32'd0, v[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10];
    logic [31:0] w;
    int          k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = ops[k];
    return w;
  endfunction

  // Drive one cycle at the falling edge, enqueue on acceptance, drop in-flight work on flush.
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl,
                       output logic fire);
    @(negedge clk);
    in_valid  = v;
    inst      = w;
    out_ready = ordy;
    flush     = fl;
    #3;
    fire = in_valid && in_ready64;
    if (in_valid && in_ready64) q64.push_back(ref_model(w, 64));
    if (in_valid && in_ready32) q32.push_back(ref_model(w, 32));
    #1.5;
    if (fl) begin
      q64.delete();
      q32.delete();
    end
  endtask

  // RV64 monitor: compare the head of the queue whenever an output is presented.
  always begin
    @(negedge clk);
    #4;
    if (!reset) begin
      chk("err_count64", 64'(err64), 64'(exp_err64));
      if (out_valid64) begin
        if (q64.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out64_extra: out_valid=1 with nothing pending, expected out_valid=0");
        end else begin
          chk("imm64", imm64, q64[0].imm);
          chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
          chk("illegal64", 64'(illegal64), 64'(q64[0].ill));
          if (out_ready) begin
            if (q64[0].ill && exp_err64 < 255) exp_err64++;
            void'(q64.pop_front());
          end
        end
      end
    end
  end

  // RV32 monitor.
  always begin
    @(negedge clk);
    #4;
    if (!reset) begin
      chk("err_count32", 64'(err32), 64'(exp_err32));
      if (out_valid32) begin
        if (q32.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out32_extra: out_valid=1 with nothing pending, expected out_valid=0");
        end else begin
          chk("imm32", {32'd0, imm32}, q32[0].imm);
          chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
          chk("illegal32", 64'(illegal32), 64'(q32[0].ill));
          if (out_ready) begin
            if (q32[0].ill && exp_err32 < 255) exp_err32++;
            void'(q32.pop_front());
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_imm64"}, imm64, 64'd0);
    chk({tag, "_fmt64"}, 64'(fmt64), 64'd0);
    chk({tag, "_illegal64"}, 64'(illegal64), 64'd0);
    chk({tag, "_err64"}, 64'(err64), 64'd0);
    chk({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_imm32"}, 64'(imm32), 64'd0);
    chk({tag, "_err32"}, 64'(err32), 64'd0);
  endtask

  // Assert reset between edges; outputs must clear without a clock edge.
  task automatic midstream_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("reset");
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    q64.delete();
    q32.delete();
    exp_err64 = 0;
    exp_err32 = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_in_ready64", 64'(in_ready64), 64'd1);
    chk("reset_in_ready32", 64'(in_ready32), 64'd1);
  endtask

  // Single instruction with fixed expectations and a latency check.
  task automatic directed(input string nm, input logic [31:0] w,
                          input logic [63:0] e64, input logic [2:0] f64,
                          input logic [63:0] e32, input logic [2:0] f32);
    logic fire;
    cycle(1'b1, w, 1'b1, 1'b0, fire);
    chk({nm, "_accept"}, 64'(fire), 64'd1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk({nm, "_lat_early"}, 64'(out_valid64), 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk({nm, "_lat_due"}, 64'(out_valid64), 64'd1);
    chk({nm, "_imm64"}, imm64, e64);
    chk({nm, "_fmt64"}, 64'(fmt64), 64'(f64));
    chk({nm, "_ill64"}, 64'(illegal64), 64'(f64 == 3'd0));
    chk({nm, "_imm32"}, 64'(imm32), e32);
    chk({nm, "_fmt32"}, 64'(fmt32), 64'(f32));
    chk({nm, "_ill32"}, 64'(illegal32), 64'(f32 == 3'd0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        fire;
    logic [31:0] bp [4];
    int          acc;
    int          cyc;

    reset = 1'b1; in_valid = 1'b0; inst = 32'd0; flush = 1'b0; out_ready = 1'b1;
    #1;
    check_zero_outputs("init");
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("init_in_ready64", 64'(in_ready64), 64'd1);

    directed("addi",   32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFFFF_FFFF, 3'd1);
    directed("slli63", 32'h03F09093, 64'd63, 3'd6, 64'd31, 3'd6);
    directed("slli31", 32'h01F09093, 64'd31, 3'd6, 64'd31, 3'd6);
    directed("bad7f",  32'h0000007F, 64'd0, 3'd0, 64'd0, 3'd0);
    directed("addiw",  32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'd0, 3'd0);
    directed("slliw",  32'h0210909B, 64'd1, 3'd6, 64'd0, 3'd0);

    // S, B, U back to back at full throughput.
    cycle(1'b1, 32'hFE112E23, 1'b1, 1'b0, fire);
    cycle(1'b1, 32'hFE000CE3, 1'b1, 1'b0, fire);
    cycle(1'b1, 32'h800000B7, 1'b1, 1'b0, fire);
    chk("stream_s_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("stream_s_fmt", 64'(fmt64), 64'd2);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("stream_b_imm", imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("stream_b_fmt", 64'(fmt64), 64'd3);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("stream_u_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("stream_u_fmt", 64'(fmt64), 64'd4);
    chk("stream_u_imm32", 64'(imm32), 64'h8000_0000);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);

    // Backpressure: out_ready low for the first three cycles.
    bp[0] = 32'h00100093; bp[1] = 32'hFE112E23; bp[2] = 32'h800000B7; bp[3] = 32'h0000007F;
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 20) begin
      cycle(1'b1, bp[acc], (cyc >= 3), 1'b0, fire);
      if (cyc == 2) chk("bp_in_ready_full", 64'(in_ready64), 64'd0);
      if (fire) acc++;
      cyc++;
    end
    chk("bp_all_accepted", 64'(acc), 64'd4);
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("bp_drained64", 64'(q64.size()), 64'd0);
    chk("bp_drained32", 64'(q32.size()), 64'd0);

    // Flush with both stages full.
    cycle(1'b1, 32'h12345013, 1'b0, 1'b0, fire);
    cycle(1'b1, 32'h876540EF, 1'b0, 1'b0, fire);
    cycle(1'b1, 32'h00000013, 1'b0, 1'b1, fire);
    chk("flush_in_ready", 64'(in_ready64), 64'd0);
    chk("flush_no_accept", 64'(fire), 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, fire);
    chk("flush_out_valid", 64'(out_valid64), 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("flush_empty_out_valid", 64'(out_valid64), 64'd0);
    chk("flush_in_ready_after", 64'(in_ready64), 64'd1);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 8), rand_inst(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 49) == 0), fire);
    end
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("rand_drained64", 64'(q64.size()), 64'd0);
    chk("rand_drained32", 64'(q32.size()), 64'd0);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'h0000007F, 1'b1, 1'b0, fire);
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("err_sat64", 64'(err64), 64'd255);
    chk("err_sat32", 64'(err32), 64'd255);

    // Fill the pipe, then reset in the middle of the stream.
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0, fire);
    cycle(1'b1, 32'h800000B7, 1'b0, 1'b0, fire);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, fire);
    chk("pre_reset_valid", 64'(out_valid64), 64'd1);
    midstream_reset();
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("post_reset_out_valid", 64'(out_valid64), 64'd0);
    directed("post_reset_addi", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFFFF_FFFF, 3'd1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, fire);
    chk("final_drained64", 64'(q64.size()), 64'd0);
    chk("final_drained32", 64'(q32.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
